alu181_nibble_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu181_nibble_seq.sv | 115 +++++++++++
 tb/tb_alu181_nibble_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial 74181 sequencer.
// Holds the FSM state enum, the slice width and named 74181 select codes.
package alu_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // mode 0 (arithmetic)
  localparam logic [3:0] SEL_A_PLUS_B  = 4'b1001;
  localparam logic [3:0] SEL_A_MINUS_B = 4'b0110;
  // mode 1 (logic)
  localparam logic [3:0] SEL_XOR       = 4'b0110;
  localparam logic [3:0] SEL_F_EQ_A    = 4'b1111;

endpackage

// File: rtl/alu181_nibble_seq.sv
// Runs a WIDTH-bit 74181 op through one external 4-bit slice, LSB nibble first.
// Ports: clk/rst_n, start+a/b/select/mode/cin in, busy/done/f/cout/aeqb out,
// alu_* drive/receive the slice. aeqb compare built only with ALU_SEQ_AEQB_EN.
module alu181_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       select,
  input  logic             mode,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             aeqb,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_select,
  output logic             alu_mode,
  output logic             alu_cin,
  input  logic [3:0]       alu_f,
  input  logic             alu_cout
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW      = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t                    state;
  logic [IW-1:0]             idx;
  logic [WIDTH-1:0]          a_q;
  logic [WIDTH-1:0]          b_q;
  logic [3:0]                sel_q;
  logic                      mode_q;
  logic                      cin_q;
  logic                      carry_q;
  // top nibble goes straight from alu_f into f, so it is never stored
  logic [WIDTH-NIBBLE_W-1:0] work;

  // idx is parked at 0 outside RUN, so nibble 0 shows in IDLE/DONE
  assign alu_a      = a_q[idx*NIBBLE_W +: NIBBLE_W];
  assign alu_b      = b_q[idx*NIBBLE_W +: NIBBLE_W];
  assign alu_select = sel_q;
  assign alu_mode   = mode_q;
  // both ends active-low: forward raw
  assign alu_cin    = (idx == '0) ? cin_q : carry_q;

`ifndef ALU_SEQ_AEQB_EN
  assign aeqb = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      f       <= '0;
      cout    <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      carry_q <= 1'b1;
      work    <= '0;
`ifdef ALU_SEQ_AEQB_EN
      aeqb    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            sel_q  <= select;
            mode_q <= mode;
            cin_q  <= cin;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          carry_q <= alu_cout;
          if (idx == LAST) begin
            f     <= {alu_f, work};
            cout  <= alu_cout;
`ifdef ALU_SEQ_AEQB_EN
            aeqb  <= &{alu_f, work};
`endif
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            work[idx*NIBBLE_W +: NIBBLE_W] <= alu_f;
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu181_nibble_seq.sv
// Bench for alu181_nibble_seq: behavioural 74181 slice plus wide reference.
// Scoreboard queue filled at issue, drained by a done-driven monitor.
module tb_alu181_nibble_seq;
  import alu_seq_pkg::*;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic [3:0]       select;
  logic             mode, cin;
  logic             busy, done, cout, aeqb;
  logic [WIDTH-1:0] f;
  logic [3:0]       alu_a, alu_b, alu_select, alu_f;
  logic             alu_mode, alu_cin, alu_cout;

  alu181_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .select(select), .mode(mode), .cin(cin),
    .busy(busy), .done(done), .f(f), .cout(cout), .aeqb(aeqb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_mode(alu_mode), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // 4-bit slice: 74181 internal generate/propagate terms
  logic [3:0] sx, sy;
  logic [4:0] ssum;
  always_comb begin
    sx = alu_a | (alu_b & {4{alu_select[0]}})
               | (~alu_b & {4{alu_select[1]}});
    sy = (alu_a & ~alu_b & {4{alu_select[2]}})
       | (alu_a & alu_b & {4{alu_select[3]}});
    ssum = {1'b0, sx} + {1'b0, sy} + {4'b0, ~alu_cin};
    alu_cout = ~ssum[4];
    alu_f = alu_mode ? ~(sx ^ sy) : ssum[3:0];
  end

  typedef struct {
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             aeqb;
    int               cyc;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_seen = 0;
  logic [WIDTH-1:0] last_f = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Wide reference from the 74181 function table.
  function automatic exp_t model(input logic [WIDTH-1:0] ia, ib,
                                 input logic [3:0] s,
                                 input logic m, c);
    exp_t r;
    logic [WIDTH-1:0] ones, x, y, lg;
    logic [WIDTH:0]   sum;
    ones = '1;
    case (s)
      4'b0000: begin x = ia;        y = '0;        end // A
      4'b0001: begin x = ia | ib;   y = '0;        end // A|B
      4'b0010: begin x = ia | ~ib;  y = '0;        end // A|~B
      4'b0011: begin x = ones;      y = '0;        end // -1
      4'b0100: begin x = ia;        y = ia & ~ib;  end
      4'b0101: begin x = ia | ib;   y = ia & ~ib;  end
      4'b0110: begin x = ia;        y = ~ib;       end // A-B-1
      4'b0111: begin x = ia & ~ib;  y = ones;      end
      4'b1000: begin x = ia;        y = ia & ib;   end
      4'b1001: begin x = ia;        y = ib;        end // A+B
      4'b1010: begin x = ia | ~ib;  y = ia & ib;   end
      4'b1011: begin x = ia & ib;   y = ones;      end
      4'b1100: begin x = ia;        y = ia;        end // 2A
      4'b1101: begin x = ia | ib;   y = ia;        end
      4'b1110: begin x = ia | ~ib;  y = ia;        end
      default: begin x = ia;        y = ones;      end // A-1
    endcase
    case (s)
      4'b0000: lg = ~ia;
      4'b0001: lg = ~(ia | ib);
      4'b0010: lg = ~ia & ib;
      4'b0011: lg = '0;
      4'b0100: lg = ~(ia & ib);
      4'b0101: lg = ~ib;
      4'b0110: lg = ia ^ ib;
      4'b0111: lg = ia & ~ib;
      4'b1000: lg = ~ia | ib;
      4'b1001: lg = ~(ia ^ ib);
      4'b1010: lg = ib;
      4'b1011: lg = ia & ib;
      4'b1100: lg = ones;
      4'b1101: lg = ia | ~ib;
      4'b1110: lg = ia | ib;
      default: lg = ia;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ~c};
    r.f    = m ? lg : sum[WIDTH-1:0];
    r.cout = ~sum[WIDTH];
`ifdef ALU_SEQ_AEQB_EN
    r.aeqb = (r.f == ones);
`else
    r.aeqb = 1'b0;
`endif
    r.cyc  = 0;
    return r;
  endfunction

  // Monitor: every done pops one expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got done=1 expected none pending");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("f", f, e.f);
        check("cout", cout, e.cout);
        check("aeqb", aeqb, e.aeqb);
        check("latency", cyc, e.cyc + NIB);
        last_f = e.f;
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] ia, ib,
                       input logic [3:0] is,
                       input logic im, ic);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      check("issue_timeout", busy, 0);
      return;
    end
    a = ia; b = ib; select = is; mode = im; cin = ic;
    start = 1'b1;
    e = model(ia, ib, is, im, ic);
    e.cyc = cyc + 1;
    sbq.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    int n;
    int ds;
    rst_n = 1'b0; start = 1'b0;
    a = '0; b = '0; select = '0; mode = 1'b0; cin = 1'b1;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_f", f, 0);
    check("rst_cout", cout, 1);
    check("rst_aeqb", aeqb, 0);
    check("rst_alu_a", alu_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(16'h1234, 16'h0FFF, SEL_A_PLUS_B, 1'b0, 1'b1);
    issue(16'hFFFF, 16'h0001, SEL_A_PLUS_B, 1'b0, 1'b1);
    issue(16'h0005, 16'h0003, SEL_A_MINUS_B, 1'b0, 1'b0);
    issue(16'h0003, 16'h0005, SEL_A_MINUS_B, 1'b0, 1'b0);
    issue(16'hF0F0, 16'hFF00, SEL_XOR, 1'b1, 1'b1);
    // accepted in DONE: RUN must follow with no IDLE cycle
    issue(16'hA5A5, 16'h0F0F, SEL_XOR, 1'b1, 1'b1);
    @(negedge clk);
    check("b2b_busy", busy, 1);
    // start pulse mid-RUN carries junk operands that must be ignored
    start = 1'b1; a = 16'h1111; b = 16'h2222; select = 4'b0000;
    @(posedge clk);
    #1 start = 1'b0;
    issue(16'hFFFF, 16'h0000, SEL_F_EQ_A, 1'b1, 1'b1);
    issue(16'hFFFE, 16'h0000, SEL_F_EQ_A, 1'b1, 1'b1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) repeat (2) @(negedge clk);
      issue(WIDTH'($urandom), WIDTH'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom));
    end

    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sbq.size(), 0);
    repeat (3) @(negedge clk);
    check("f_hold", f, last_f);

    // reset two RUN edges into an op
    issue(16'h1234, 16'h4321, SEL_A_PLUS_B, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_f", f, 0);
    check("midrst_cout", cout, 1);
    check("midrst_done", done, 0);
    sbq.delete();
    ds = done_seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_done", done_seen, ds);
    check("midrst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
